// File: rtl/norm_unit.sv
// norm_unit: iterative Re/Im normalizer (start/busy/done handshake; mode/sgn select, Res_x/ShiftAmount_x/Zero_x results)
module norm_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int SA_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] InA_Re,
  input  logic [DATA_WIDTH-1:0] InA_Im,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Res_Re,
  output logic [DATA_WIDTH-1:0] Res_Im,
  output logic [SA_WIDTH-1:0]   ShiftAmount_Re,
  output logic [SA_WIDTH-1:0]   ShiftAmount_Im,
  output logic                  Zero_Re,
  output logic                  Zero_Im
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [SA_WIDTH-1:0] SA_MAX = SA_WIDTH'(DATA_WIDTH - 1);
  localparam logic [SA_WIDTH-1:0] SA_ONE = SA_WIDTH'(1);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [SA_WIDTH-1:0] sre_q, sre_d, sim_q, sim_d;
  logic zre_q, zre_d, zim_q, zim_d, mode_q, mode_d, sgn_q, sgn_d, done_q, done_d;
  logic stop_re, stop_im, fin;
  assign stop_re = (sgn_q ? re_q[DATA_WIDTH-1] ^ re_q[DATA_WIDTH-2] : re_q[DATA_WIDTH-1]) | (sre_q == SA_MAX);
  assign stop_im = (sgn_q ? im_q[DATA_WIDTH-1] ^ im_q[DATA_WIDTH-2] : im_q[DATA_WIDTH-1]) | (sim_q == SA_MAX);
  // complex mode ends on the first stopped lane so both lanes keep a common amount
  assign fin = mode_q ? stop_re | stop_im : stop_re & stop_im;
  always_comb begin
    state_d = state_q;
    re_d    = re_q;
    im_d    = im_q;
    sre_d   = sre_q;
    sim_d   = sim_q;
    zre_d   = zre_q;
    zim_d   = zim_q;
    mode_d  = mode_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        re_d    = InA_Re;
        im_d    = InA_Im;
        sre_d   = '0;
        sim_d   = '0;
        zre_d   = InA_Re == '0;
        zim_d   = InA_Im == '0;
        mode_d  = mode;
        sgn_d   = sgn;
      end
    end else if (fin) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      re_d  = stop_re ? re_q : re_q << 1;
      sre_d = stop_re ? sre_q : sre_q + SA_ONE;
      im_d  = stop_im ? im_q : im_q << 1;
      sim_d = stop_im ? sim_q : sim_q + SA_ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      re_q    <= '0;
      im_q    <= '0;
      sre_q   <= '0;
      sim_q   <= '0;
      zre_q   <= 1'b0;
      zim_q   <= 1'b0;
      mode_q  <= 1'b0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      re_q    <= re_d;
      im_q    <= im_d;
      sre_q   <= sre_d;
      sim_q   <= sim_d;
      zre_q   <= zre_d;
      zim_q   <= zim_d;
      mode_q  <= mode_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
    end
  end
  assign busy           = state_q == SHIFT;
  assign done           = done_q;
  assign Res_Re         = re_q;
  assign Res_Im         = im_q;
  assign ShiftAmount_Re = sre_q;
  assign ShiftAmount_Im = sim_q;
  assign Zero_Re        = zre_q;
  assign Zero_Im        = zim_q;
endmodule

// File: tb/tb_norm_unit.sv
// tb_norm_unit: scoreboard bench for norm_unit (DATA_WIDTH 16)
module tb_norm_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, sgn = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic busy, done, zre, zim;
  logic [15:0] res_re, res_im;
  logic [3:0] sa_re, sa_im;
  typedef struct {
    logic [15:0] re, im;
    logic [3:0] sre, sim;
    logic zre, zim;
    int lat, t0;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_err = 0;
  norm_unit dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sgn(sgn),
    .InA_Re(in_re), .InA_Im(in_im), .busy(busy), .done(done),
    .Res_Re(res_re), .Res_Im(res_im), .ShiftAmount_Re(sa_re), .ShiftAmount_Im(sa_im),
    .Zero_Re(zre), .Zero_Im(zim)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // redundant leading bits: leading zeros (unsigned) or leading sign copies minus one (signed), capped at 15
  function automatic int amount(input logic [15:0] x, input logic s);
    int n = 0;
    logic lead;
    lead = s ? x[15] : 1'b0;
    for (int i = 15; i >= 0 && x[i] == lead; i--) n++;
    if (s) n--;
    return n > 15 ? 15 : n;
  endfunction
  task automatic push(input logic m, input logic s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ka, kb;
    ka = amount(a, s);
    kb = amount(b, s);
    if (m) begin
      ka = ka < kb ? ka : kb;
      kb = ka;
    end
    e.sre = 4'(ka);
    e.sim = 4'(kb);
    e.re = a << ka;
    e.im = b << kb;
    e.zre = a == 0;
    e.zim = b == 0;
    e.lat = (ka > kb ? ka : kb) + 1;
    e.t0 = cyc + 1;
    q.push_back(e);
  endtask
  task automatic drive(input logic m, input logic s, input logic [15:0] a, input logic [15:0] b);
    mode = m;
    sgn = s;
    in_re = a;
    in_im = b;
    start = 1'b1;
    push(m, s, a, b);
  endtask
  task automatic op(input logic m, input logic s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    drive(m, s, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("timeout_pending", q.size(), 0);
  endtask
  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"}, {res_re, res_im}, 0);
    chk({tag, "_sa"}, {sa_re, sa_im}, 0);
    chk({tag, "_zero"}, {zre, zim}, 0);
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("spurious_done", done, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("res_re", res_re, e.re);
        chk("res_im", res_im, e.im);
        chk("sa_re", sa_re, e.sre);
        chk("sa_im", sa_im, e.sim);
        chk("zero_re", zre, e.zre);
        chk("zero_im", zim, e.zim);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_done", busy, 0);
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    op(0, 0, 16'h0001, 16'h4000);
    wait_empty();
    op(1, 0, 16'h0001, 16'h4000);
    wait_empty();
    op(0, 1, 16'hFFF0, 16'h0003);
    wait_empty();
    op(0, 0, 16'h0000, 16'h8000);
    wait_empty();
    op(0, 0, 16'h8000, 16'hC000);
    wait_empty();
    op(1, 0, 16'h0000, 16'h0100);
    wait_empty();
    op(0, 1, 16'hFFFF, 16'h0000);
    wait_empty();
    // start pulses while busy must be ignored; a start in the done cycle is taken
    op(0, 0, 16'h0001, 16'h4000);
    repeat (2) @(negedge clk);
    mode = 1'b1;
    sgn = 1'b1;
    in_re = 16'h1234;
    in_im = 16'h0000;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    drive(1, 0, 16'h0001, 16'h4000);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_empty();
    // reset mid-operation aborts silently and clears results
    op(0, 0, 16'h0001, 16'h4000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_cleared("abort");
    repeat (20) @(negedge clk);
    chk("abort_no_done_busy", busy, 0);
    op(0, 0, 16'h0001, 16'h4000);
    wait_empty();
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a, b;
      logic s;
      s = 1'($urandom);
      a = 16'($urandom) >> $urandom_range(0, 15);
      b = 16'($urandom) >> $urandom_range(0, 15);
      if (s && $urandom_range(0, 1) == 1) a = ~a;
      if (s && $urandom_range(0, 1) == 1) b = ~b;
      op(1'($urandom), s, a, b);
      wait_empty();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/norm_unit.md
# norm_unit

Iterative normalizer for the complex ALU datapath. It computes, for each of the Re and Im lanes, the left-shift amount that normalizes the operand, and returns both the normalized value and that amount. The amount it returns is the same amount the ALU shifter's SLL would need to produce that value, so the shifter's normalized results can be reproduced and its shift amounts recovered. One bit is resolved per cycle behind a start/busy/done handshake. The block sits beside the shifter in the ALU and feeds scaling and priority-encode operations.

## Interface
Parameters:
- DATA_WIDTH, default 16, lane width in bits.
- SA_WIDTH, default $clog2(DATA_WIDTH), width of a shift amount.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only while idle.
- mode  input  1  0 = simple math (lanes independent); 1 = complex math (one common shift amount).
- sgn  input  1  0 = unsigned (count leading zeros); 1 = signed (count redundant sign bits).
- InA_Re  input  DATA_WIDTH  Re operand.
- InA_Im  input  DATA_WIDTH  Im operand.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- Res_Re  output  DATA_WIDTH  normalized Re value.
- Res_Im  output  DATA_WIDTH  normalized Im value.
- ShiftAmount_Re  output  SA_WIDTH  left shift applied to Re.
- ShiftAmount_Im  output  SA_WIDTH  left shift applied to Im.
- Zero_Re  output  1  InA_Re was 0.
- Zero_Im  output  1  InA_Im was 0.

## Operation
- States: IDLE, SHIFT.
- **IDLE, start = 1:**
  - Capture InA_Re/Im into the lane registers.
  - Latch mode and sgn.
  - Clear both amount counters.
  - Set Zero_x from the operands.
  - Set busy = 1 and go to SHIFT.
- **IDLE, start = 0:** outputs hold their previous values.
- **Per-lane stop condition**, evaluated on the current lane register:
  - unsigned: bit[W-1] == 1;
  - signed: bit[W-1] != bit[W-2];
  - any mode: the lane counter has reached DATA_WIDTH-1.
- **Simple mode:**
  - Each SHIFT cycle, every lane that has not stopped shifts left by 1 (zero fill) and increments its counter.
  - A stopped lane holds.
  - Finish when both lanes have stopped.
- **Complex mode:**
  - Both lanes shift together while neither has stopped.
  - Finish as soon as either lane stops.
  - This gives the common amount, the minimum of the two per-lane amounts.
  - ShiftAmount_Re == ShiftAmount_Im.
- **Finish** (the SHIFT cycle in which the finish condition holds):
  - No shift in that cycle.
  - done = 1 for one cycle, busy = 0, return to IDLE.
- Res_x, ShiftAmount_x and Zero_x hold until the next accepted start.
- **Invariant:** Res_x == InA_x << ShiftAmount_x, truncated to DATA_WIDTH.
- **Zero operand:**
  - Shifts to the DATA_WIDTH-1 limit; Res = 0, Zero = 1.
  - In complex mode the other lane decides the amount.
- **Signed all-ones operand:** shifts to the limit and yields only the MSB set.
- start while busy is ignored and has no effect on the running operation.

## Timing
- **Reset:**
  - All outputs go to 0 and the state goes to IDLE on the first edge with rst = 1.
  - rst mid-operation aborts it: no done pulse, and any held results are cleared.
- **Start acceptance:** start is sampled at edge E0; busy is high from E0 on.
- **Shifting:** with N = number of shift steps (the max lane amount in simple mode, the common amount in complex mode), edges E1..EN shift.
- **Completion:**
  - E(N+1) asserts done and deasserts busy.
  - done is high for exactly the cycle following E(N+1).
- **Latency:** start-to-done is N+1 cycles. Minimum is 1 (already normalized); maximum is DATA_WIDTH.
- **Back-to-back:** start may be high in the cycle done is high. It is accepted at that edge (state is IDLE), so there is no dead cycle.
- **Counters:** width SA_WIDTH; they never exceed DATA_WIDTH-1, so no wrap.

## Test plan
All scenarios use DATA_WIDTH = 16.
1. **Unsigned, simple mode:** sgn=0, mode=0, Re=0x0001, Im=0x4000, start -> done 16 cycles after start; Res_Re=0x8000, SA_Re=15; Res_Im=0x8000, SA_Im=1; Zero flags 0.
2. **Complex mode:** same operands, mode=1 -> done 2 cycles after start; SA_Re=SA_Im=1; Res_Re=0x0002, Res_Im=0x8000.
3. **Signed, simple mode:** sgn=1, mode=0, Re=0xFFF0, Im=0x0003 -> SA_Re=11, Res_Re=0x8000; SA_Im=13, Res_Im=0x6000; done 14 cycles after start.
4. **Zero and normalized operands:** sgn=0, mode=0, Re=0x0000, Im=0x8000 -> Zero_Re=1, SA_Re=15, Res_Re=0; SA_Im=0, Res_Im=0x8000. Repeat with Re=0x8000, Im=0xC000 -> done 1 cycle after start, both amounts 0.
5. **Start while busy:** start pulses during scenario 1 -> results and done timing unchanged. A second start in the done cycle is accepted, with busy high the next cycle.
6. **Reset mid-operation:** rst=1 for one cycle at cycle 5 of scenario 1 -> no done pulse, all outputs 0, busy 0; the next start behaves as from power-up.
